// File: rtl/run_control_pkg.sv
// Shared definitions for the core run controller: FSM state encoding and
// the default counter width.
package run_control_pkg;

  localparam int unsigned CW_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_HOLD  = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/run_control_sat_counter.sv
// CW-wide up-counter with enable that sticks at all-ones instead of wrapping.
// The asynchronous active-low clear doubles as the block reset.
module sat_counter #(
  parameter int unsigned CW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {CW{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/run_control.sv
// Sequences reset and halt for a core, counts elapsed cycles and retired
// instructions, and stops the core once the cycle budget is spent.
module run_control
  import run_control_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 3,
  parameter int unsigned HALT_CYCLES  = 4,
  parameter int unsigned CW           = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          retire,
  input  logic          ext_halt,
  input  logic [CW-1:0] run_limit,
  output logic          core_reset,
  output logic          core_halt,
  output logic          done,
  output logic [CW-1:0] cycle_count,
  output logic [CW-1:0] insn_count
);

  localparam logic [CW-1:0] RST_LIM = CW'(RESET_CYCLES);
  localparam logic [CW-1:0] HLT_LIM = CW'(HALT_CYCLES);
  localparam logic          SKIP_HOLD = (HALT_CYCLES <= RESET_CYCLES);

  state_e        state_q;
  state_e        state_d;
  logic          ext_halt_q;
  logic [CW-1:0] cyc_next;
  logic          limit_hit;
  logic          cyc_en;
  logic          ins_en;

  // Transitions look at the value the cycle counter takes on this edge.
  assign cyc_next  = (cycle_count == {CW{1'b1}}) ? cycle_count : cycle_count + 1'b1;
  assign limit_hit = (run_limit != '0) && (cyc_next >= run_limit);
  assign cyc_en    = (state_q != S_DONE);
  assign ins_en    = retire && !core_reset && !core_halt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: if (cyc_next >= RST_LIM) state_d = SKIP_HOLD ? S_RUN : S_HOLD;
      S_HOLD:  if (cyc_next >= HLT_LIM) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_DONE:  state_d = S_DONE;
    endcase
    if ((state_q != S_DONE) && limit_hit) begin
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RESET;
      ext_halt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ext_halt_q <= ext_halt;
    end
  end

  // Outputs come only from flops, so the core sees glitch-free controls.
  assign core_reset = (state_q == S_RESET);
  assign core_halt  = (state_q != S_RUN) || ext_halt_q;
  assign done       = (state_q == S_DONE);

  sat_counter #(.CW(CW)) u_cycles (
    .clk_i   (clk),
    .rst_ni  (reset),
    .en_i    (cyc_en),
    .count_o (cycle_count)
  );

  sat_counter #(.CW(CW)) u_insns (
    .clk_i   (clk),
    .rst_ni  (reset),
    .en_i    (ins_en),
    .count_o (insn_count)
  );

endmodule

// File: tb/tb_run_control.sv
// Bench for run_control: a per-edge scoreboard on the default instance plus
// directed checks on a skip-hold instance and a 4-bit saturation instance.
module tb_run_control;

  localparam int W = 67;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        retire;
  logic        ext_halt;
  logic        c_retire;
  logic [31:0] run_limit;
  logic [31:0] b_limit;
  logic [3:0]  c_limit;

  logic        a_rst, a_halt, a_done;
  logic [31:0] a_cyc, a_ins;
  logic        b_rst, b_halt, b_done;
  logic [31:0] b_cyc, b_ins;
  logic        c_rst, c_halt, c_done;
  logic [3:0]  c_cyc, c_ins;

  run_control u_a (
    .clk(clk), .reset(reset), .retire(retire), .ext_halt(ext_halt),
    .run_limit(run_limit), .core_reset(a_rst), .core_halt(a_halt),
    .done(a_done), .cycle_count(a_cyc), .insn_count(a_ins)
  );

  run_control #(.RESET_CYCLES(5), .HALT_CYCLES(2)) u_b (
    .clk(clk), .reset(reset), .retire(retire), .ext_halt(1'b0),
    .run_limit(b_limit), .core_reset(b_rst), .core_halt(b_halt),
    .done(b_done), .cycle_count(b_cyc), .insn_count(b_ins)
  );

  run_control #(.CW(4)) u_c (
    .clk(clk), .reset(reset), .retire(c_retire), .ext_halt(1'b0),
    .run_limit(c_limit), .core_reset(c_rst), .core_halt(c_halt),
    .done(c_done), .cycle_count(c_cyc), .insn_count(c_ins)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  logic        m_done, m_ext_q;
  logic [31:0] m_cyc, m_ins;
  int          halt_hi;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_a();
    return {a_rst, a_halt, a_done, a_cyc, a_ins};
  endfunction

  // Reference: reset while fewer than 3 cycles, halt while fewer than 4
  // (or done, or the registered pause request), counters frozen once done.
  task automatic model_step();
    logic r, h;
    logic [31:0] nxt;
    r = !m_done && (m_cyc < 32'd3);
    h = m_done || (m_cyc < 32'd4) || m_ext_q;
    if (!m_done) begin
      if (retire && !r && !h && (m_ins != 32'hFFFF_FFFF)) m_ins = m_ins + 1;
      nxt = (m_cyc == 32'hFFFF_FFFF) ? m_cyc : m_cyc + 1;
      if ((run_limit != 0) && (nxt >= run_limit)) m_done = 1'b1;
      m_cyc = nxt;
    end
    m_ext_q = ext_halt;
    r = !m_done && (m_cyc < 32'd3);
    h = m_done || (m_cyc < 32'd4) || m_ext_q;
    exp_q.push_back({r, h, m_done, m_cyc, m_ins});
  endtask

  task automatic tick();
    logic [W-1:0] e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("sb", pack_a(), e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_a", pack_a(), {3'b110, 64'd0});
    check("rst_b", {b_rst, b_halt, b_done, b_cyc, b_ins}, {3'b110, 64'd0});
    check("rst_c", {c_rst, c_halt, c_done, c_cyc, c_ins}, {3'b110, 8'd0});
    m_done = 1'b0; m_ext_q = 1'b0; m_cyc = '0; m_ins = '0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; retire = 1'b0; ext_halt = 1'b0; c_retire = 1'b1;
    run_limit = '0; b_limit = '0; c_limit = '0;

    // Unlimited run, no retires; B and C are checked alongside.
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 2) check("p1_rst_e2", a_rst, 1);
      if (i == 3) check("p1_rst_e3", a_rst, 0);
      if (i == 3) check("p1_halt_e3", a_halt, 1);
      if (i == 4) check("p1_halt_e4", a_halt, 0);
      if (i == 4) check("b_e4", {b_rst, b_halt}, 2'b11);
      if (i == 5) check("b_e5", {b_rst, b_halt}, 2'b00);
      if (i == 30) check("c_sat", {c_cyc, c_ins}, {4'hF, 4'hF});
    end
    check("p1_cyc100", a_cyc, 100);
    check("p1_nodone", a_done, 0);

    // Budget of 64 cycles with a retire every cycle.
    run_limit = 32'd64; retire = 1'b1;
    do_reset();
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 63) check("p2_done_e63", a_done, 0);
      if (i == 64) check("p2_done_e64", {a_done, a_halt}, 2'b11);
      if (i == 64) check("p2_cyc", a_cyc, 64);
      if (i == 64) check("p2_ins", a_ins, 60);
      if (i == 70) check("p2_frozen", {a_cyc, a_ins}, {32'd64, 32'd60});
    end

    // Pause requested on edges 10..19 under a 30-cycle budget.
    run_limit = 32'd30; retire = 1'b1; halt_hi = 0;
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      ext_halt = (i >= 10 && i <= 19);
      tick();
      if (i >= 5 && i <= 29 && a_halt) halt_hi++;
      if (i == 9)  check("p3_halt_e9", a_halt, 0);
      if (i == 10) check("p3_halt_e10", a_halt, 1);
      if (i == 19) check("p3_halt_e19", a_halt, 1);
      if (i == 20) check("p3_halt_e20", a_halt, 0);
      if (i == 30) check("p3_done", a_done, 1);
      if (i == 30) check("p3_ins", a_ins, 16);
    end
    check("p3_halt_cycles", halt_hi, 10);
    ext_halt = 1'b0;

    // Random traffic, then a mid-run asynchronous reset and a lowered budget.
    run_limit = '0;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      retire   = 1'($urandom_range(0, 1));
      ext_halt = 1'($urandom_range(0, 1));
      tick();
    end
    #2;
    do_reset();
    retire = 1'b1; ext_halt = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    check("p4_restart", {a_rst, a_halt, a_cyc}, {2'b00, 32'd10});
    run_limit = 32'd5;
    tick();
    check("p4_lowered", {a_done, a_cyc, a_ins}, {1'b1, 32'd11, 32'd7});
    tick();
    check("p4_frozen", a_cyc, 11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
